// File: rtl/float_to_fix_pkg.sv
// Shared float definitions: IEEE-754 single field layout, value classes and
// the stage records used by the float-to-fixed pipeline.
package float_pkg;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int FIX_W    = 32;
  localparam int MAG_W    = 56;
  localparam int SH_W     = 10;
  localparam int STAGES   = 3;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fclass_t;

  typedef struct packed {
    logic            sign;
    logic [MANT_W:0] mant;
    logic [SH_W-1:0] sh;
    fclass_t         cls;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
    logic             ovf;
    fclass_t          cls;
  } s2_t;

  function automatic logic f_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [MANT_W-1:0] f_frac(input logic [31:0] f);
    return f[22:0];
  endfunction
endpackage

// File: rtl/float_to_fix_if.sv
// Streaming float-in / fixed-out bus; master drives floats, slave returns results.
interface float_to_fix_if;
  import float_pkg::*;
  logic             in_valid;
  logic [31:0]      in_float;
  logic             out_valid;
  logic [FIX_W-1:0] out_fix;
  logic             out_ovf;
  logic             out_nan;

  modport master (output in_valid, in_float, input out_valid, out_fix, out_ovf, out_nan);
  modport slave  (input in_valid, in_float, output out_valid, out_fix, out_ovf, out_nan);
endinterface

// File: rtl/float_to_fix_shift.sv
// Bidirectional barrel shifter: left for sh >= 0, truncating right for sh < 0.
module fix_shift
  import float_pkg::*;
(
  input  logic [MANT_W:0]        mant,
  input  logic signed [SH_W-1:0] sh,
  output logic [MAG_W-1:0]       mag,
  output logic                   ovf
);
  logic [SH_W-1:0] rsh;

  always_comb begin
    mag = '0;
    ovf = 1'b0;
    rsh = SH_W'(-sh);
    if (!sh[SH_W-1]) begin
      // Beyond 31 the result cannot fit in 32 bits whatever the mantissa.
      if (sh > 10'sd31) ovf = 1'b1;
      else              mag = MAG_W'(mant) << sh[4:0];
    end else if (rsh < 10'd24) begin
      mag = MAG_W'(mant >> rsh[4:0]);
    end
  end
endmodule

// File: rtl/float_to_fix.sv
// IEEE-754 single to signed 32-bit fixed point (FRAC_BITS fraction bits).
// Input register, then unpack, shift and saturate stages; no backpressure.
module float_to_fix
  import float_pkg::*;
#(
  parameter int FRAC_BITS = 16
)(
  input logic           MAIN_CLK,
  input logic           RST,
  float_to_fix_if.slave bus
);
  localparam logic [MAG_W-1:0] MAG_LIM = 56'h8000_0000;
  localparam logic [FIX_W-1:0] FIX_MAX = 32'h7FFF_FFFF;
  localparam logic [FIX_W-1:0] FIX_MIN = 32'h8000_0000;

  logic [STAGES:0]  vld_pipe;
  logic [31:0]      in_r;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic [MAG_W-1:0] sh_mag;
  logic             sh_ovf;
  logic [FIX_W-1:0] fix_d, fix_q;
  logic             ovf_d, ovf_q, nan_d, nan_q;

  always_ff @(posedge MAIN_CLK) begin
    if (RST) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
  end

  always_ff @(posedge MAIN_CLK) begin
    in_r <= bus.in_float;
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  // Unpack/classify; denormals flush to zero.
  always_comb begin
    s1_d.sign = f_sign(in_r);
    s1_d.mant = {1'b1, f_frac(in_r)};
    s1_d.sh   = SH_W'(int'(f_exp(in_r)) - EXP_BIAS - MANT_W + FRAC_BITS);
    if (f_exp(in_r) == '0)            s1_d.cls = ZERO;
    else if (f_exp(in_r) != '1)       s1_d.cls = NORMAL;
    else if (f_frac(in_r) == '0)      s1_d.cls = INF;
    else                              s1_d.cls = NAN;
  end

  fix_shift u_shift (
    .mant (s1_q.mant),
    .sh   ($signed(s1_q.sh)),
    .mag  (sh_mag),
    .ovf  (sh_ovf)
  );

  always_comb s2_d = '{sign: s1_q.sign, mag: sh_mag, ovf: sh_ovf, cls: s1_q.cls};

  // Negative side reaches one further: exactly 2^31 maps to FIX_MIN unflagged.
  always_comb begin
    fix_d = '0;
    ovf_d = 1'b0;
    nan_d = 1'b0;
    unique case (s2_q.cls)
      NAN: nan_d = 1'b1;
      INF: begin
        ovf_d = 1'b1;
        fix_d = s2_q.sign ? FIX_MIN : FIX_MAX;
      end
      NORMAL: begin
        if (!s2_q.sign) begin
          if (s2_q.ovf || s2_q.mag >= MAG_LIM) begin
            ovf_d = 1'b1;
            fix_d = FIX_MAX;
          end else fix_d = s2_q.mag[FIX_W-1:0];
        end else begin
          if (s2_q.ovf || s2_q.mag > MAG_LIM) begin
            ovf_d = 1'b1;
            fix_d = FIX_MIN;
          end else fix_d = -s2_q.mag[FIX_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge MAIN_CLK) begin
    if (RST || !vld_pipe[STAGES-1]) begin
      fix_q <= '0;
      ovf_q <= 1'b0;
      nan_q <= 1'b0;
    end else begin
      fix_q <= fix_d;
      ovf_q <= ovf_d;
      nan_q <= nan_d;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_fix   = fix_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_nan   = nan_q;
endmodule

// File: tb/tb_float_to_fix.sv
// Bench for float_to_fix (FRAC_BITS = 16): directed values, streaming with a
// bubble against a reference model, and reset with values in flight.
module tb_float_to_fix;
  typedef struct packed {
    logic [31:0] fix;
    logic        ovf;
    logic        nan;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  res_t q[$];

  float_to_fix_if bus ();

  float_to_fix #(.FRAC_BITS(16)) dut (
    .MAIN_CLK (clk),
    .RST      (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] f);
    res_t   r;
    int     e, sh;
    longint mag, v;
    r = '0;
    e = int'(f[30:23]);
    if (e == 255) begin
      if (f[22:0] != 0) r.nan = 1'b1;
      else begin
        r.ovf = 1'b1;
        r.fix = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return r;
    end
    if (e == 0) return r;
    sh = e - 150 + 16;
    if (sh >= 32) begin
      r.ovf = 1'b1;
      r.fix = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return r;
    end
    mag = longint'({1'b1, f[22:0]});
    if (sh >= 0)       mag = mag << sh;
    else if (sh > -32) mag = mag >> (-sh);
    else               mag = 0;
    v = f[31] ? -mag : mag;
    if (v > 64'sd2147483647) begin
      r.ovf = 1'b1;
      r.fix = 32'h7FFF_FFFF;
    end else if (v < -64'sd2147483648) begin
      r.ovf = 1'b1;
      r.fix = 32'h8000_0000;
    end else r.fix = v[31:0];
    return r;
  endfunction

  // Scoreboard: pop on every output; idle outputs must be clean.
  always @(negedge clk) begin
    res_t e;
    if (bus.out_valid === 1'b1) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output fix=%h ovf=%b nan=%b, none expected", bus.out_fix, bus.out_ovf, bus.out_nan);
      end else begin
        e = q.pop_front();
        if ({bus.out_fix, bus.out_ovf, bus.out_nan} !== e) begin
          n_fail++;
          $display("FAIL scoreboard got fix=%h ovf=%b nan=%b, want fix=%h ovf=%b nan=%b",
                   bus.out_fix, bus.out_ovf, bus.out_nan, e.fix, e.ovf, e.nan);
        end
      end
    end else if (rst === 1'b0) begin
      n_tests++;
      if ({bus.out_valid, bus.out_fix, bus.out_ovf, bus.out_nan} !== '0) begin
        n_fail++;
        $display("FAIL idle_clean got valid=%b fix=%h ovf=%b nan=%b, want all 0",
                 bus.out_valid, bus.out_fix, bus.out_ovf, bus.out_nan);
      end
    end
  end

  task automatic send(input logic [31:0] f, input res_t e);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_float = f;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain %0d results still pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_float = 32'h3F80_0000;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.out_valid, bus.out_fix, bus.out_ovf, bus.out_nan} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got valid=%b fix=%h ovf=%b nan=%b, want all 0",
               bus.out_valid, bus.out_fix, bus.out_ovf, bus.out_nan);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send(32'h3F80_0000, '{32'h0001_0000, 1'b0, 1'b0});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.in_valid = 1'b0;
      n_tests++;
      if (bus.out_valid !== (k == 4)) begin
        n_fail++;
        $display("FAIL latency cycle %0d out_valid=%b want %b", k, bus.out_valid, (k == 4));
      end
    end
    send(32'hC020_0000, '{32'hFFFD_8000, 1'b0, 1'b0});
    drain();
  endtask

  task automatic test_lsb();
    send(32'h3780_0000, '{32'h0000_0001, 1'b0, 1'b0});
    send(32'h3700_0000, '{32'h0000_0000, 1'b0, 1'b0});
    send(32'h0000_0001, '{32'h0000_0000, 1'b0, 1'b0});
    send(32'h8000_0000, '{32'h0000_0000, 1'b0, 1'b0});
    drain();
  endtask

  task automatic test_range();
    send(32'h471C_4000, '{32'h7FFF_FFFF, 1'b1, 1'b0});
    send(32'hC700_0000, '{32'h8000_0000, 1'b0, 1'b0});
    send(32'hC700_0100, '{32'h8000_0000, 1'b1, 1'b0});
    send(32'h46FF_FFFE, '{32'h7FFF_FF00, 1'b0, 1'b0});
    send(32'h7F00_0000, '{32'h7FFF_FFFF, 1'b1, 1'b0});
    drain();
  endtask

  task automatic test_specials();
    send(32'h7FC0_0000, '{32'h0000_0000, 1'b0, 1'b1});
    send(32'h7F80_0000, '{32'h7FFF_FFFF, 1'b1, 1'b0});
    send(32'hFF80_0000, '{32'h8000_0000, 1'b1, 1'b0});
    send(32'hFF80_0001, '{32'h0000_0000, 1'b0, 1'b1});
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[12];
    logic [11:0] pat;
    logic        want;
    pat = 12'b1111_1001_1111;
    vals[0] = 32'h3F80_0000;
    vals[1] = 32'hC020_0000;
    vals[2] = 32'h4049_0FDB;
    vals[3] = 32'hBF00_0000;
    vals[4] = 32'h4680_0000;
    for (int i = 5; i < 12; i++)
      vals[i] = {1'($urandom), 8'(110 + $urandom_range(0, 36)), 23'($urandom)};
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      want = (k >= 4 && k < 16) ? pat[k-4] : 1'b0;
      n_tests++;
      if (bus.out_valid !== want) begin
        n_fail++;
        $display("FAIL stream_valid cycle %0d out_valid=%b want %b", k, bus.out_valid, want);
      end
      if (k < 12) begin
        bus.in_valid = pat[k];
        bus.in_float = vals[k];
        if (pat[k]) q.push_back(model(vals[k]));
      end else bus.in_valid = 1'b0;
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_float = 32'h3F80_0000 + 32'(i << 20);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.in_float = 32'h4000_0000;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.out_valid, bus.out_fix, bus.out_ovf, bus.out_nan} !== '0) begin
        n_fail++;
        $display("FAIL reset_flush cycle %0d valid=%b fix=%h ovf=%b nan=%b, want all 0",
                 k, bus.out_valid, bus.out_fix, bus.out_ovf, bus.out_nan);
      end
    end
    send(32'h3F80_0000, '{32'h0001_0000, 1'b0, 1'b0});
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_float = '0;
    test_reset();
    test_basic();
    test_lsb();
    test_range();
    test_specials();
    test_back_to_back();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
